// File: rtl/hazard_pkg.sv
// Shared constants for the ID/EX hazard control unit.
package hazard_pkg;
  localparam int unsigned DEF_REG_ADDR_W    = 5;
  localparam int unsigned ZERO_REG          = 0;
  localparam int unsigned DEF_LOAD_LATENCY  = 1;
  localparam int unsigned DEF_MULDIV_CYCLES = 32;
  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned LOAD_CNT_W        = 3;
  localparam int unsigned MULDIV_CNT_W      = 6;
endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter that stops at zero and flags when it is nonzero.
module hazard_down_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_nonzero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load_en) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// ID/EX hazard control: multi-cycle load-use stalls, HI/LO scoreboard,
// fetch flush on redirect and saturating stall/flush performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = DEF_REG_ADDR_W,
  parameter int unsigned LOAD_LATENCY  = DEF_LOAD_LATENCY,
  parameter int unsigned MULDIV_CYCLES = DEF_MULDIV_CYCLES,
  parameter int unsigned DELAY_SLOT    = 0,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_destination_reg,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rs,
  input  logic                  if_id_uses_rt,
  input  logic                  if_id_hilo_access,
  input  logic                  ex_muldiv_start,
  input  logic                  branch_taken,
  input  logic                  jump,
  input  logic                  perf_clear,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_flush,
  output logic                  muldiv_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  logic             w_lu_hit;
  logic             w_load_start;
  logic             w_load_nz;
  logic             w_muldiv_nz;
  logic             w_stall;
  logic             w_flush;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  assign w_lu_hit = id_ex_mem_read
                  & (id_ex_destination_reg != REG_ADDR_W'(ZERO_REG))
                  & ((if_id_uses_rs & (id_ex_destination_reg == if_id_rs))
                   | (if_id_uses_rt & (id_ex_destination_reg == if_id_rt)));

  // The hit cycle itself is the first stall cycle, so the counter covers the rest.
  assign w_load_start = w_lu_hit & ~w_load_nz;

  hazard_down_counter #(.W(LOAD_CNT_W)) u_load_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load_en  (w_load_start),
    .i_load_val (LOAD_CNT_W'(LOAD_LATENCY - 1)),
    .o_nonzero  (w_load_nz)
  );

  hazard_down_counter #(.W(MULDIV_CNT_W)) u_muldiv_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load_en  (ex_muldiv_start),
    .i_load_val (MULDIV_CNT_W'(MULDIV_CYCLES)),
    .o_nonzero  (w_muldiv_nz)
  );

  assign w_stall = ~reset & (w_lu_hit | w_load_nz | (if_id_hilo_access & w_muldiv_nz));
  assign w_flush = FLUSH_EN & ~reset & (branch_taken | jump) & ~w_stall;

  assign pc_write     = ~w_stall;
  assign if_id_write  = ~w_stall;
  assign id_ex_bubble = w_stall;
  assign if_flush     = w_flush;
  assign muldiv_busy  = w_muldiv_nz;

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (perf_clear) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized + directed bench for hazard_control_unit, two configurations
// checked every cycle against a cycle-window reference model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mr = 1'b0;
  logic [4:0] dest = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic       urs = 1'b0;
  logic       urt = 1'b0;
  logic       hilo = 1'b0;
  logic       start = 1'b0;
  logic       br = 1'b0;
  logic       jmp = 1'b0;
  logic       clr = 1'b0;

  logic       pc_a, ifid_a, bub_a, fl_a, busy_a;
  logic [5:0] sc_a, fc_a;
  logic       pc_b, ifid_b, bub_b, fl_b, busy_b;
  logic [7:0] sc_b, fc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_ADDR_W(5), .LOAD_LATENCY(3), .MULDIV_CYCLES(4), .DELAY_SLOT(0), .CNT_W(6)
  ) u_dut_a (
    .clk(clk), .reset(reset), .id_ex_mem_read(mr), .id_ex_destination_reg(dest),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(urs), .if_id_uses_rt(urt),
    .if_id_hilo_access(hilo), .ex_muldiv_start(start), .branch_taken(br), .jump(jmp),
    .perf_clear(clr), .pc_write(pc_a), .if_id_write(ifid_a), .id_ex_bubble(bub_a),
    .if_flush(fl_a), .muldiv_busy(busy_a), .stall_cycles(sc_a), .flush_count(fc_a)
  );

  hazard_control_unit #(
    .REG_ADDR_W(5), .LOAD_LATENCY(1), .MULDIV_CYCLES(2), .DELAY_SLOT(1), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .id_ex_mem_read(mr), .id_ex_destination_reg(dest),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(urs), .if_id_uses_rt(urt),
    .if_id_hilo_access(hilo), .ex_muldiv_start(start), .branch_taken(br), .jump(jmp),
    .perf_clear(clr), .pc_write(pc_b), .if_id_write(ifid_b), .id_ex_bubble(bub_b),
    .if_flush(fl_b), .muldiv_busy(busy_b), .stall_cycles(sc_b), .flush_count(fc_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each hazard is a window of cycle indices rather than a counter.
  int p_ll[2] = '{3, 1};
  int p_mc[2] = '{4, 2};
  int p_ds[2] = '{0, 1};
  int p_max[2] = '{63, 255};
  int load_end[2] = '{-1, -1};
  int busy_until[2] = '{-1, -1};
  int sc_m[2] = '{0, 0};
  int fc_m[2] = '{0, 0};
  int cyc = 0;

  task automatic model_check(input int k, input logic pc, input logic ifid,
                             input logic bub, input logic fl, input logic busy,
                             input int sc, input int fc);
    bit hit, stl, fle, bsy;
    string s;
    s = $sformatf("[%0d]", k);
    if (reset) begin
      load_end[k] = -1; busy_until[k] = -1; sc_m[k] = 0; fc_m[k] = 0;
      stl = 0; fle = 0; bsy = 0;
    end else begin
      hit = mr && (int'(dest) != 0) &&
            ((urs && dest == rs) || (urt && dest == rt));
      bsy = (cyc <= busy_until[k]);
      stl = hit || (cyc <= load_end[k]) || (hilo && bsy);
      fle = (p_ds[k] == 0) && (br || jmp) && !stl;
    end
    chk({"pc_write", s}, int'(pc), int'(!stl));
    chk({"if_id_write", s}, int'(ifid), int'(!stl));
    chk({"id_ex_bubble", s}, int'(bub), int'(stl));
    chk({"if_flush", s}, int'(fl), int'(fle));
    chk({"muldiv_busy", s}, int'(busy), int'(bsy));
    chk({"stall_cycles", s}, sc, sc_m[k]);
    chk({"flush_count", s}, fc, fc_m[k]);
    if (!reset) begin
      if (hit && cyc > load_end[k]) load_end[k] = cyc + p_ll[k] - 1;
      if (start) busy_until[k] = cyc + p_mc[k];
      if (clr) begin
        sc_m[k] = 0; fc_m[k] = 0;
      end else begin
        if (stl && sc_m[k] < p_max[k]) sc_m[k]++;
        if (fle && fc_m[k] < p_max[k]) fc_m[k]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_check(0, pc_a, ifid_a, bub_a, fl_a, busy_a, int'(sc_a), int'(fc_a));
      model_check(1, pc_b, ifid_b, bub_b, fl_b, busy_b, int'(sc_b), int'(fc_b));
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mr = 0; dest = '0; rs = '0; rt = '0; urs = 0; urt = 0;
    hilo = 0; start = 0; br = 0; jmp = 0; clr = 0;
  endtask

  task automatic hazard();
    mr = 1; dest = 5'd8; rs = 5'd8; urs = 1;
  endtask

  initial begin
    // Load hazard presented during reset must not stall.
    step(); hazard(); #1;
    chk("rst_pc_write", int'(pc_a), 1);
    chk("rst_bubble", int'(bub_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    step(); reset = 0; #1;
    chk("lu_a_c1_pc", int'(pc_a), 0);
    chk("lu_a_c1_bubble", int'(bub_a), 1);
    chk("lu_b_c1_pc", int'(pc_b), 0);
    step(); mr = 0; #1;
    chk("lu_a_c2_pc", int'(pc_a), 0);
    chk("lu_b_c2_pc", int'(pc_b), 1);
    chk("lu_b_stall_cycles", int'(sc_b), 1);
    step(); #1;
    chk("lu_a_c3_pc", int'(pc_a), 0);
    step(); #1;
    chk("lu_a_c4_pc", int'(pc_a), 1);
    chk("lu_a_stall_cycles", int'(sc_a), 3);

    // $zero destination and unused rt never hazard.
    mr = 1; dest = 5'd0; rs = 5'd0; urs = 1; #1;
    chk("zero_reg_pc", int'(pc_a), 1);
    chk("zero_reg_ifid", int'(ifid_a), 1);
    urs = 0; dest = 5'd9; rt = 5'd9; urt = 0; #1;
    chk("unused_rt_pc", int'(pc_a), 1);
    idle();

    // Mult/div busy window and reload while busy.
    step(); start = 1; #1;
    chk("md_start_busy", int'(busy_a), 0);
    step(); start = 0; hilo = 1; #1;
    chk("md_busy_1", int'(busy_a), 1);
    chk("md_bubble_1", int'(bub_a), 1);
    repeat (3) begin
      step(); #1;
      chk("md_busy_n", int'(busy_a), 1);
      chk("md_pc_n", int'(pc_a), 0);
    end
    step(); #1;
    chk("md_release_busy", int'(busy_a), 0);
    chk("md_release_pc", int'(pc_a), 1);
    hilo = 0;
    step(); start = 1;
    step(); start = 0;
    step();
    step(); start = 1;
    repeat (4) begin
      step(); start = 0; #1;
      chk("md_reload_busy", int'(busy_a), 1);
    end
    step(); #1;
    chk("md_reload_end", int'(busy_a), 0);

    // Redirects: flush when free, suppressed under stall, none in delay-slot mode.
    step(); br = 1; #1;
    chk("br_flush_a", int'(fl_a), 1);
    chk("br_flush_b", int'(fl_b), 0);
    step(); br = 0; #1;
    chk("flush_count_a", int'(fc_a), 1);
    chk("flush_count_b", int'(fc_b), 0);
    step(); hazard(); br = 1; #1;
    chk("br_in_stall", int'(fl_a), 0);
    step(); idle(); jmp = 1; #1;
    chk("jmp_ds_b", int'(fl_b), 0);
    chk("jmp_in_stall_a", int'(fl_a), 0);
    idle();
    repeat (2) step();

    // Reset mid load stall.
    step(); hazard();
    step(); mr = 0; #1;
    chk("mid_stall_pc", int'(pc_a), 0);
    reset = 1; #1;
    chk("mid_rst_pc", int'(pc_a), 1);
    chk("mid_rst_sc", int'(sc_a), 0);
    chk("mid_rst_fc", int'(fc_a), 0);
    step(); reset = 0; idle();

    // perf_clear at stall_cycles=5 while stalling.
    step(); hazard();
    repeat (4) step();
    step(); clr = 1; #1;
    chk("pre_clear_sc", int'(sc_a), 5);
    chk("pre_clear_bub", int'(bub_a), 1);
    step(); clr = 0; #1;
    chk("post_clear_sc", int'(sc_a), 0);

    // Saturation at all-ones.
    repeat (70) step();
    #1;
    chk("sat_sc", int'(sc_a), 63);
    step(); #1;
    chk("sat_hold_sc", int'(sc_a), 63);
    idle();

    // Randomized traffic, checked by the model every cycle.
    repeat (3000) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      mr    = ($urandom_range(0, 2) == 0);
      dest  = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      urs   = 1'($urandom_range(0, 1));
      urt   = 1'($urandom_range(0, 1));
      hilo  = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 9) == 0);
      br    = ($urandom_range(0, 3) == 0);
      jmp   = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 39) == 0);
    end
    step(); idle(); reset = 0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
